// File: rtl/iagc_status_hold_if.sv
// -----------------------------------------------------------------------------
// iagc_status_hold_if
// Bus between the raw IAGC status source and the status-hold block.
//
// Signals:
//   i_iagc_status    : raw status code from the core FSM
//   i_clear_overflow : one-cycle pulse that clears o_overflow
//   o_status         : held status presented to the LED unit
//   o_fifo_level     : number of pending statuses (0..FIFO_DEPTH)
//   o_overflow       : sticky, a status was coalesced into a full queue
//   o_hold_state     : debug view of the display FSM (0 = IDLE, 1 = HOLD)
//
// Handshake: there is no valid/ready pair. The input status is sampled on
// every rising clock edge and a change against the previous sample is an
// implicit push. The outputs are registered and valid every cycle.
//
// Modports:
//   master : the status source / observer
//   slave  : the status-hold block
// -----------------------------------------------------------------------------
interface iagc_status_hold_if #(
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int FIFO_ADDR        = 2
);
  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status;
  logic                        i_clear_overflow;
  logic [IAGC_STATUS_SIZE-1:0] o_status;
  logic [FIFO_ADDR:0]          o_fifo_level;
  logic                        o_overflow;
  logic                        o_hold_state;

  modport master (
    output i_iagc_status,
    output i_clear_overflow,
    input  o_status,
    input  o_fifo_level,
    input  o_overflow,
    input  o_hold_state
  );

  modport slave (
    input  i_iagc_status,
    input  i_clear_overflow,
    output o_status,
    output o_fifo_level,
    output o_overflow,
    output o_hold_state
  );
endinterface

// File: rtl/iagc_status_hold.sv
// -----------------------------------------------------------------------------
// iagc_status_hold
// Stretches short-lived IAGC core status codes so they are visible on an LED.
// Every change of the raw status is queued in a small FIFO; each queued status
// is then shown on o_status for at least HOLD_TICKS cycles.
//
// Ports:
//   i_clock : system clock, rising edge
//   i_reset : synchronous, active-low reset
//   bus     : iagc_status_hold_if.slave (status in, clear pulse, held status,
//             queue level, sticky overflow, FSM debug state)
//
// Optional feature macro: IAGC_STATUS_HOLD_ERROR_PRIORITY_EN
//   When defined, a change to CMD_ERROR (0110) flushes the queue and is shown
//   on the next edge, restarting the hold. When undefined, CMD_ERROR is
//   queued like any other status.
// -----------------------------------------------------------------------------
module iagc_status_hold #(
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int HOLD_TICKS       = 10000000,
  parameter int FIFO_DEPTH       = 4,
  parameter int FIFO_ADDR        = 2
) (
  input logic          i_clock,
  input logic          i_reset,
  iagc_status_hold_if.slave bus
);

  localparam int CNT_W = $clog2(HOLD_TICKS);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(HOLD_TICKS - 1);
  localparam logic [FIFO_ADDR:0]   LVL_FULL  = (FIFO_ADDR+1)'(FIFO_DEPTH);
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_CMD_ERROR = IAGC_STATUS_SIZE'(6);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [IAGC_STATUS_SIZE-1:0] prev_q;
  logic [IAGC_STATUS_SIZE-1:0] mem [FIFO_DEPTH];
  logic [FIFO_ADDR-1:0]        wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR:0]          level_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IAGC_STATUS_SIZE-1:0] status_q, status_d;
  logic                        ovf_q;

  logic push, pop, empty, full, err_push, write_new, coalesce;

  assign push  = (bus.i_iagc_status != prev_q);
  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_FULL);

`ifdef IAGC_STATUS_HOLD_ERROR_PRIORITY_EN
  assign err_push = push && (bus.i_iagc_status == ST_CMD_ERROR);
`else
  assign err_push = 1'b0;
`endif

  // A push into a full queue with no pop replaces the newest entry, so the
  // latest core status always reaches the display eventually.
  assign write_new = push && !err_push && (!full || pop);
  assign coalesce  = push && !err_push && full && !pop;

  // Display FSM: next state, hold counter, displayed status and pop request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    pop      = 1'b0;
    if (err_push) begin
      state_d  = ST_HOLD;
      cnt_d    = '0;
      status_d = ST_CMD_ERROR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            pop      = 1'b1;
            status_d = mem[rd_ptr_q];
            cnt_d    = '0;
            state_d  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (!empty) begin
              // Back-to-back reload: next status shown with no idle gap.
              pop      = 1'b1;
              status_d = mem[rd_ptr_q];
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      status_q <= '0;
      prev_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      prev_q   <= bus.i_iagc_status;

      if (err_push) begin
        // Flush: the error is displayed directly, not queued.
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (write_new) wr_ptr_q <= wr_ptr_q + FIFO_ADDR'(1);
        if (pop)       rd_ptr_q <= rd_ptr_q + FIFO_ADDR'(1);
        if (write_new && !pop)      level_q <= level_q + (FIFO_ADDR+1)'(1);
        else if (pop && !write_new) level_q <= level_q - (FIFO_ADDR+1)'(1);
      end

      // Set wins over a simultaneous clear.
      if (coalesce)                  ovf_q <= 1'b1;
      else if (bus.i_clear_overflow) ovf_q <= 1'b0;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      if (write_new)     mem[wr_ptr_q]                  <= bus.i_iagc_status;
      else if (coalesce) mem[wr_ptr_q - FIFO_ADDR'(1)] <= bus.i_iagc_status;
    end
  end

  assign bus.o_status     = status_q;
  assign bus.o_fifo_level = level_q;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_hold_state = (state_q == ST_HOLD);

endmodule

// File: doc/iagc_status_hold.md
Name: iagc_status_hold

Overview:
- Sits between the IAGC core controller's raw status output and the PMOD LED unit.
- Core FSM states such as CMD_PARSE, CMD_ERROR and SAMPLE often last only a few clocks, too short to see on an LED.
- This block detects every status change, queues it in a small FIFO, and presents each queued status for a minimum HOLD_TICKS cycles on o_status.
- o_status feeds the LED unit's status input directly.

Parameters:
- IAGC_STATUS_SIZE, 4, width of status code.
- HOLD_TICKS, 10000000, minimum cycles each displayed status is held (100 ms @ 100 MHz); must be >= 2.
- FIFO_DEPTH, 4, pending-status queue depth; power of 2, >= 2.
- FIFO_ADDR, 2, log2(FIFO_DEPTH).

Ports:
- i_clock, in, 1, system clock; all logic on rising edge.
- i_reset, in, 1, synchronous, active-low reset.
- i_iagc_status, in, IAGC_STATUS_SIZE, raw status from the core FSM.
- i_clear_overflow, in, 1, one-cycle pulse that clears o_overflow.
- o_status, out, IAGC_STATUS_SIZE, held status to the LED unit.
- o_fifo_level, out, FIFO_ADDR+1, number of queued entries (0..FIFO_DEPTH).
- o_overflow, out, 1, sticky flag: a status was coalesced because the FIFO was full.

Behaviour:
- Reset (i_reset==0 at clock edge):
  - o_status=0000 (RESET), prev_status=0000, FIFO empty, o_fifo_level=0, o_overflow=0, hold counter=0, FSM=IDLE.
  - Reset asserted mid-hold aborts immediately; queued entries are discarded.
- Change detect: prev_status registers i_iagc_status every cycle. Push when i_iagc_status != prev_status. The first cycle after reset compares against 0000.
- FSM IDLE:
  - If FIFO is non-empty: pop the head, load o_status, clear the counter, go to HOLD.
  - Otherwise stay in IDLE; o_status is unchanged.
- FSM HOLD:
  - The counter increments each cycle.
  - When counter==HOLD_TICKS-1 and the FIFO is non-empty: pop, load o_status, counter=0, stay in HOLD. This is a back-to-back reload with no gap.
  - When counter==HOLD_TICKS-1 and the FIFO is empty: go to IDLE; o_status holds its value.
  - Each popped value is therefore visible for exactly HOLD_TICKS cycles when further entries are pending.
- Latency, from IDLE with an empty FIFO: status changes on the input at edge N → pushed at N+1 → o_status updates at N+2.
- FIFO full, push without a simultaneous pop:
  - The incoming value overwrites the most recently written entry (tail-1). Level is unchanged and o_overflow is set.
  - This guarantees the latest core status is always eventually displayed.
- FIFO full, push with a simultaneous pop: normal push and pop, level unchanged, no overflow.
- Push and pop in the same cycle with the FIFO empty: no bypass. The value is queued and popped on a later cycle.
- o_overflow clear: i_clear_overflow clears it. If a set and a clear occur in the same cycle, set wins.
- o_fifo_level: registered and exact. Push only → +1, pop only → -1, both → unchanged.
- Pointer wrap: pointers are FIFO_ADDR bits wide and wrap modulo FIFO_DEPTH.
- Hold counter: width is ceil(log2(HOLD_TICKS)) and it never exceeds HOLD_TICKS-1.

Optional Feature:
- Macro: IAGC_STATUS_HOLD_ERROR_PRIORITY_EN.
- Defined: a detected change to CMD_ERROR (0110) has priority.
  - On the push cycle, the FIFO is flushed (level=0).
  - On the next edge, o_status=0110 and the counter=0, regardless of the current hold progress.
  - CMD_ERROR is then held for HOLD_TICKS cycles; later changes queue normally.
  - o_overflow is not affected by the flush.
- Undefined: CMD_ERROR is queued and displayed like any other status.

Test Plan (HOLD_TICKS=4, FIFO_DEPTH=4):
1. Reset: i_reset=0 for 3 cycles, input=0101 → o_status=0000, o_fifo_level=0, o_overflow=0. Release reset with input=0000 → no push; o_status stays 0000.
2. Single change: input 0000→0010 at edge N, then held → o_status=0010 from N+2 onward. After 4 cycles the FSM returns to IDLE and o_status stays 0010.
3. Burst: input 0001, 0010, 0011 on consecutive cycles → o_status = 0001×4 cycles, 0010×4, 0011 held thereafter. o_fifo_level peaks at 2.
4. Overflow: 7 distinct values on consecutive cycles (0001..0111) during a hold → o_overflow=1, o_fifo_level=4. The final displayed value is 0111; values in the overwritten slot are skipped.
5. Overflow clear: pulse i_clear_overflow in the same cycle as a new overflow event → o_overflow stays 1. A clear pulse alone → 0 the next cycle.
6. Reset mid-hold with 3 entries queued → next cycle o_status=0000, o_fifo_level=0.
7. Error priority: with the macro defined, push 0110 while 0010 is held with 2 entries queued → o_status=0110 one cycle after the push, level=0. Without the macro, 0110 appears only after the queued entries.
